// File: rtl/baud_frac_gen_pkg.sv
// Shared constants and types for the fractional-N UART baud tick generator.
package baud_frac_gen_pkg;

  localparam int DEF_INT_W    = 16;
  localparam int DEF_FRAC_W   = 4;
  localparam int DEF_OSR      = 16;
  // 50 MHz / (115200 * 16) = 27.126 -> 27 + 2/16 clk per rx tick
  localparam int DEF_DIV_INT  = 27;
  localparam int DEF_DIV_FRAC = 2;

  // Divisor update handshake: IDLE accepts a request, PEND waits for a tx tick
  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/baud_frac_gen_div.sv
// One fractional-N divider: integer period plus a fractional accumulator whose
// overflow lengthens the following period by one clock.
module baud_frac_gen_div
  import baud_frac_gen_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);

  logic [INT_W-1:0]  cnt_q;
  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [INT_W:0]    period;
  logic [FRAC_W:0]   acc_sum;
  logic              terminal;

  // Period is compared one bit wider so div_int at its maximum plus a carry cannot wrap
  assign period   = {1'b0, div_int} + {{INT_W{1'b0}}, carry_q};
  assign terminal = ({1'b0, cnt_q} == (period - (INT_W+1)'(1)));
  assign acc_sum  = {1'b0, acc_q} + {1'b0, div_frac};
  assign tick     = en & terminal;

  // Count 0..P-1; on the terminal cycle fold in the fraction and latch its carry for the next period
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (!en || clear) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (terminal) begin
      cnt_q   <= '0;
      acc_q   <= acc_sum[FRAC_W-1:0];
      carry_q <= acc_sum[FRAC_W];
    end else begin
      cnt_q   <= cnt_q + INT_W'(1);
    end
  end

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional-N baud tick generator: rxclk_en at OSR x baud, txclk_en at baud,
// with a runtime-programmable divisor applied on a tx bit boundary.
module baud_frac_gen
  import baud_frac_gen_pkg::*;
#(
  parameter int INT_W    = DEF_INT_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int OSR      = DEF_OSR,
  parameter int DEF_INT  = DEF_DIV_INT,
  parameter int DEF_FRAC = DEF_DIV_FRAC
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rx_resync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INT_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              cfg_err,
  output logic              rxclk_en,
  output logic              txclk_en
);

  localparam int OS_W = (OSR > 1) ? $clog2(OSR) : 1;

  cfg_state_t        state_q, state_d;
  logic [INT_W-1:0]  act_int_q, shd_int_q;
  logic [FRAC_W-1:0] act_frac_q, shd_frac_q;
  logic              cfg_err_q;
  logic [OS_W-1:0]   os_cnt_q;
  logic              rx_tick, tx_tick, tx_bit;
  logic              capture, reject, apply;
  logic              cfg_illegal;

  assign cfg_illegal = (cfg_div_int < INT_W'(2));
  assign tx_bit      = tx_tick & (os_cnt_q == OS_W'(OSR - 1));

  baud_frac_gen_div #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_rx_div (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (apply | rx_resync),
    .div_int  (act_int_q),
    .div_frac (act_frac_q),
    .tick     (rx_tick)
  );

  baud_frac_gen_div #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_tx_div (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (apply),
    .div_int  (act_int_q),
    .div_frac (act_frac_q),
    .tick     (tx_tick)
  );

  // Config handshake: accept or reject in IDLE, apply the shadow divisor on the next tx bit (or at once when stopped)
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    reject  = 1'b0;
    apply   = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_valid) begin
          if (cfg_illegal) begin
            reject = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = CFG_PEND;
          end
        end
      end
      CFG_PEND: begin
        if (tx_bit || !en) begin
          apply   = 1'b1;
          state_d = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  // FSM state, error pulse and the shadow/active divisor registers
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CFG_IDLE;
      cfg_err_q  <= 1'b0;
      shd_int_q  <= INT_W'(DEF_INT);
      shd_frac_q <= FRAC_W'(DEF_FRAC);
      act_int_q  <= INT_W'(DEF_INT);
      act_frac_q <= FRAC_W'(DEF_FRAC);
    end else begin
      state_q   <= state_d;
      cfg_err_q <= reject;
      if (capture) begin
        shd_int_q  <= cfg_div_int;
        shd_frac_q <= cfg_div_frac;
      end
      if (apply) begin
        act_int_q  <= shd_int_q;
        act_frac_q <= shd_frac_q;
      end
    end
  end

  // Oversample counter: counts tx-divider ticks so txclk_en lands on every OSR-th one
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt_q <= '0;
    end else if (!en || apply) begin
      os_cnt_q <= '0;
    end else if (tx_tick) begin
      os_cnt_q <= (os_cnt_q == OS_W'(OSR - 1)) ? '0 : os_cnt_q + OS_W'(1);
    end
  end

  // A resync pulse hides a coinciding rx tick, except on the apply cycle which takes precedence
  assign rxclk_en  = rx_tick & ~(rx_resync & ~apply);
  assign txclk_en  = tx_bit;
  assign cfg_ready = (state_q == CFG_IDLE);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Directed bench for baud_frac_gen with a closed-form tick-time model checked every cycle.
module tb_baud_frac_gen;

  localparam int FRAC_W = 4;
  localparam int OSR    = 16;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rx_resync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div_int;
  logic [3:0]  cfg_div_frac;
  logic        cfg_err;
  logic        rxclk_en;
  logic        txclk_en;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rx_q[$];
  int tx_q[$];

  // Model state: active/shadow divisor, pending flag, and per-divider restart cycle + next tick index
  int m_int, m_frac, m_sh_int, m_sh_frac;
  int m_pend, m_err;
  int rx_t0, rx_k, tx_t0, tx_k;

  baud_frac_gen dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .en           (en),
    .rx_resync    (rx_resync),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_err      (cfg_err),
    .rxclk_en     (rxclk_en),
    .txclk_en     (txclk_en)
  );

  always #10 clk_50m = ~clk_50m;

  // Cycle of the k-th tick after a restart at t0: k whole periods plus the carries of ticks 1..k-1
  function automatic int tick_time(input int t0, input int k, input int di, input int df);
    return t0 + k * di + (((k - 1) * df) >> FRAC_W) - 1;
  endfunction

  function automatic int rx_next();
    return tick_time(rx_t0, rx_k, m_int, m_frac);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  // Drive one cycle of inputs; pulse-type inputs drop back to 0 afterwards
  task automatic applyStimulus(input logic en_v, input logic resync_v, input logic valid_v,
                               input logic [15:0] di, input logic [3:0] df);
    en           = en_v;
    rx_resync    = resync_v;
    cfg_valid    = valid_v;
    cfg_div_int  = di;
    cfg_div_frac = df;
    waitCycles(1);
    rx_resync = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic modelReset();
    m_int = 27; m_frac = 2; m_sh_int = 27; m_sh_frac = 2;
    m_pend = 0; m_err = 0;
    rx_t0 = cyc + 1; rx_k = 1;
    tx_t0 = cyc + 1; tx_k = 1;
  endtask

  // Compare process: predict this cycle's outputs, compare, then advance the model
  always @(negedge clk_50m) begin
    int  rxt, txt;
    bit  e_rx_div, e_tx_div, e_rx, e_tx, apply;
    if (!rst_n) begin
      checkOutput("reset_rxclk_en", int'(rxclk_en), 0);
      checkOutput("reset_txclk_en", int'(txclk_en), 0);
      checkOutput("reset_cfg_ready", int'(cfg_ready), 1);
      checkOutput("reset_cfg_err", int'(cfg_err), 0);
      modelReset();
    end else begin
      e_rx_div = 1'b0; e_tx_div = 1'b0; e_rx = 1'b0; e_tx = 1'b0;
      if (!en) begin
        apply = (m_pend != 0);
      end else begin
        rxt      = tick_time(rx_t0, rx_k, m_int, m_frac);
        txt      = tick_time(tx_t0, tx_k, m_int, m_frac);
        e_rx_div = (cyc == rxt);
        e_tx_div = (cyc == txt);
        e_tx     = e_tx_div && ((tx_k % OSR) == 0);
        apply    = (m_pend != 0) && e_tx;
        e_rx     = e_rx_div && !(rx_resync && !apply);
      end
      checkOutput("rxclk_en", int'(rxclk_en), int'(e_rx));
      checkOutput("txclk_en", int'(txclk_en), int'(e_tx));
      checkOutput("cfg_ready", int'(cfg_ready), (m_pend == 0) ? 1 : 0);
      checkOutput("cfg_err", int'(cfg_err), m_err);

      m_err = (m_pend == 0 && cfg_valid && int'(cfg_div_int) < 2) ? 1 : 0;
      if (apply) begin
        m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0;
      end else if (m_pend == 0 && cfg_valid && int'(cfg_div_int) >= 2) begin
        m_sh_int = int'(cfg_div_int); m_sh_frac = int'(cfg_div_frac); m_pend = 1;
      end
      if (!en || apply) begin
        rx_t0 = cyc + 1; rx_k = 1;
        tx_t0 = cyc + 1; tx_k = 1;
      end else begin
        if (rx_resync) begin
          rx_t0 = cyc + 1; rx_k = 1;
        end else if (e_rx_div) begin
          rx_k++;
        end
        if (e_tx_div) tx_k++;
      end
    end
    if (rxclk_en) rx_q.push_back(cyc);
    if (txclk_en) tx_q.push_back(cyc);
    cyc++;
  end

  // Watchdog so a stuck sequence still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int start, r, e, a, n, quiet;
    rst_n = 1'b0; en = 1'b0; rx_resync = 1'b0; cfg_valid = 1'b0;
    cfg_div_int = 16'd0; cfg_div_frac = 4'd0;
    waitCycles(3);
    checkOutput("lit_reset_ready", int'(cfg_ready), 1);
    checkOutput("lit_reset_rx", int'(rxclk_en), 0);

    // Default divisor 27 + 2/16 running from reset release
    rst_n = 1'b1; en = 1'b1; start = cyc;
    rx_q.delete(); tx_q.delete();
    waitCycles(1000);
    checkOutput("lit_rx_count_ok", (rx_q.size() >= 9) ? 1 : 0, 1);
    checkOutput("lit_tx_count_ok", (tx_q.size() >= 2) ? 1 : 0, 1);
    if (rx_q.size() >= 9 && tx_q.size() >= 2) begin
      checkOutput("lit_first_rx", rx_q[0] - start, 26);
      for (int i = 0; i < 8; i++)
        checkOutput("lit_rx_interval", rx_q[i+1] - rx_q[i], (i < 7) ? 27 : 28);
      checkOutput("lit_first_tx", tx_q[0] - start, 432);
      checkOutput("lit_tx_interval", tx_q[1] - tx_q[0], 434);
    end

    // Illegal divisor: one-cycle error, no handshake, rate unchanged
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd1, 4'd0);
    checkOutput("lit_cfg_err_pulse", int'(cfg_err), 1);
    checkOutput("lit_cfg_err_ready", int'(cfg_ready), 1);
    waitCycles(1);
    checkOutput("lit_cfg_err_clear", int'(cfg_err), 0);
    rx_q.delete();
    waitCycles(300);
    checkOutput("lit_rx_span_ok", (rx_q.size() >= 9) ? 1 : 0, 1);
    if (rx_q.size() >= 9) checkOutput("lit_rx_8tick_span", rx_q[8] - rx_q[0], 217);

    // Resync landing exactly on an rx terminal cycle
    n = 0;
    while (cyc != rx_next() && n < 100) begin waitCycles(1); n++; end
    checkOutput("lit_resync_align", (cyc == rx_next()) ? 1 : 0, 1);
    rx_resync = 1'b1; r = cyc;
    #5;
    checkOutput("lit_resync_suppress", int'(rxclk_en), 0);
    waitCycles(1);
    rx_resync = 1'b0;
    n = 0;
    while (!rxclk_en && n < 60) begin waitCycles(1); n++; end
    checkOutput("lit_resync_gap", cyc - r, 27);

    // Generator disabled for 100 cycles mid-period
    waitCycles(13);
    en = 1'b0;
    quiet = rx_q.size() + tx_q.size();
    waitCycles(100);
    checkOutput("lit_en_off_quiet", rx_q.size() + tx_q.size() - quiet, 0);
    en = 1'b1; e = cyc;
    n = 0;
    while (!rxclk_en && n < 60) begin waitCycles(1); n++; end
    checkOutput("lit_en_restart", cyc - e, 26);

    // Legal update 10/0 while running: held off until the next tx bit boundary
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd10, 4'd0);
    checkOutput("lit_cfg_pending", int'(cfg_ready), 0);
    n = 0;
    while (!txclk_en && n < 1000) begin waitCycles(1); n++; end
    checkOutput("lit_apply_tx_seen", int'(txclk_en), 1);
    checkOutput("lit_pending_at_apply", int'(cfg_ready), 0);
    a = cyc;
    waitCycles(1);
    checkOutput("lit_cfg_applied", int'(cfg_ready), 1);
    rx_q.delete(); tx_q.delete();
    waitCycles(400);
    checkOutput("lit_new_count_ok", (rx_q.size() >= 2 && tx_q.size() >= 2) ? 1 : 0, 1);
    if (rx_q.size() >= 2 && tx_q.size() >= 2) begin
      checkOutput("lit_new_rx_first", rx_q[0] - a, 10);
      checkOutput("lit_new_rx_interval", rx_q[1] - rx_q[0], 10);
      checkOutput("lit_new_tx_first", tx_q[0] - a, 160);
      checkOutput("lit_new_tx_interval", tx_q[1] - tx_q[0], 160);
    end

    // Asynchronous reset in the middle of a pending update
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd5, 4'd3);
    checkOutput("lit_pend_again", int'(cfg_ready), 0);
    n = 0;
    while (cyc != rx_next() && n < 20) begin waitCycles(1); n++; end
    checkOutput("lit_pre_reset_rx", int'(rxclk_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("lit_async_rx", int'(rxclk_en), 0);
    checkOutput("lit_async_tx", int'(txclk_en), 0);
    checkOutput("lit_async_ready", int'(cfg_ready), 1);
    waitCycles(2);
    rst_n = 1'b1; start = cyc;
    rx_q.delete(); tx_q.delete();
    waitCycles(300);
    checkOutput("lit_restore_count_ok", (rx_q.size() >= 9) ? 1 : 0, 1);
    if (rx_q.size() >= 9) begin
      checkOutput("lit_restore_first", rx_q[0] - start, 26);
      checkOutput("lit_restore_27", rx_q[7] - rx_q[6], 27);
      checkOutput("lit_restore_28", rx_q[8] - rx_q[7], 28);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
